// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry and arbiter state shared with the Mandelbrot engine
package fb_pkg;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int SHIFT   = 2;
  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 8;
  localparam int FB_SIZE = FB_W * FB_H;
  typedef enum logic [1:0] {IDLE, RD_ISSUE, WR_ISSUE} state_t;
endpackage

// File: rtl/fb_scanout_arbiter_if.sv
// fb_scanout_arbiter_if: sync-generator, writer handshake and RAM port bundle
interface fb_scanout_arbiter_if;
  import fb_pkg::*;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic              video_on;
  logic              p_tick;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  modport master (
    output pixel_x, pixel_y, video_on, p_tick, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, wr_err, mem_en, mem_we, mem_addr, mem_wdata, pix_data
  );
  modport slave (
    input  pixel_x, pixel_y, video_on, p_tick, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, wr_err, mem_en, mem_we, mem_addr, mem_wdata, pix_data
  );
endinterface

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: maps screen coordinates to a downscaled frame-buffer address
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] disp_addr
);
  assign disp_addr = ADDR_W'(32'(pixel_y >> SHIFT) * 32'(FB_W) + 32'(pixel_x >> SHIFT));
endmodule

// File: rtl/fb_scanout_arbiter.sv
// fb_scanout_arbiter: shares the frame-buffer RAM, display reads first, writer takes the rest
module fb_scanout_arbiter
  import fb_pkg::*;
(
  input logic               CLK_100MHz,
  input logic               reset,
  fb_scanout_arbiter_if.slave bus
);
  state_t            state, state_n;
  logic              p_tick_d, rd_v, rise, disp_fire, blank_fire, in_range;
  logic [ADDR_W-1:0] disp_addr, addr_n;
  logic [DATA_W-1:0] wdata_n;
  fb_addr_gen u_addr_gen (.pixel_x(bus.pixel_x), .pixel_y(bus.pixel_y), .disp_addr(disp_addr));
  assign rise       = bus.p_tick & ~p_tick_d;
  assign disp_fire  = rise & bus.video_on;
  assign blank_fire = rise & ~bus.video_on;
  assign in_range   = 32'(bus.wr_addr) < 32'(FB_SIZE);
  assign bus.mem_en = state != IDLE;
  assign bus.mem_we = state == WR_ISSUE;
  always_comb begin
    state_n = disp_fire ? RD_ISSUE : (bus.wr_req && in_range) ? WR_ISSUE : IDLE;
    addr_n  = state_n == RD_ISSUE ? disp_addr : state_n == WR_ISSUE ? bus.wr_addr : bus.mem_addr;
    wdata_n = state_n == WR_ISSUE ? bus.wr_data : bus.mem_wdata;
  end
  // rd_v marks the cycle the RAM presents read data; clearing it on reset drops any read in flight
  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      p_tick_d      <= 1'b0;
      rd_v          <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.wr_ack    <= 1'b0;
      bus.wr_err    <= 1'b0;
      bus.pix_data  <= '0;
    end else begin
      state         <= state_n;
      p_tick_d      <= bus.p_tick;
      rd_v          <= state == RD_ISSUE;
      bus.mem_addr  <= addr_n;
      bus.mem_wdata <= wdata_n;
      bus.wr_ack    <= bus.wr_req & ~disp_fire;
      bus.wr_err    <= bus.wr_err | (bus.wr_req & ~disp_fire & ~in_range);
      bus.pix_data  <= blank_fire ? '0 : rd_v ? bus.mem_rdata : bus.pix_data;
    end
  end
endmodule
